// File: rtl/data_ram.sv
// Data-memory responder: byte-lane RAM plus a small MMIO window (GPIO, COUNT, COMPARE, STATUS).
// Define DATA_RAM_TIMER_EN to build the cycle counter, compare register and timer flag.
module data_ram #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ram_we,
  input  logic [1:0]  mem_ctrl,
  input  logic [31:0] alu_res,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        misalign_err
);
  localparam int AW = $clog2(DEPTH);

  logic          is_ram, is_mmio, illegal, store_ok, mmio_we;
  logic [1:0]    mmio_off;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata, word_rd, ram_load, mmio_rd;
  logic          unused_addr;

  assign is_ram      = (alu_res[31:28] == 4'h0);
  assign is_mmio     = (alu_res[31:28] == 4'h1);
  assign word_idx    = alu_res[AW+1:2];
  assign mmio_off    = alu_res[3:2];
  assign unused_addr = &{1'b0, alu_res[27:AW+2]};

  assign illegal = (mem_ctrl == 2'b11)
                 || (mem_ctrl == 2'b01 && alu_res[0])
                 || (mem_ctrl == 2'b10 && alu_res[1:0] != 2'b00)
                 || (is_mmio && mem_ctrl != 2'b10);

  assign misalign_err = illegal;
  assign store_ok     = enable && ram_we && !illegal;
  assign mmio_we      = store_ok && is_mmio;

  // RAM stores ignore reset on purpose: only the MMIO registers are reset.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = ram_write_data;
    case (mem_ctrl)
      2'b00: begin
        lane_wdata = {4{ram_write_data[7:0]}};
        lane_we    = 4'b0001 << alu_res[1:0];
      end
      2'b01: begin
        lane_wdata = {2{ram_write_data[15:0]}};
        lane_we    = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: lane_we = 4'b1111;
    endcase
    if (!(store_ok && is_ram))
      lane_we = 4'b0000;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (lane_we[gi])
          lane_mem[word_idx] <= lane_wdata[gi*8 +: 8];
      end
      assign word_rd[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_comb begin
    case (mem_ctrl)
      2'b00:   ram_load = {24'h0, 8'(word_rd >> {alu_res[1:0], 3'b000})};
      2'b01:   ram_load = {16'h0, 16'(word_rd >> {alu_res[1], 4'b0000})};
      default: ram_load = word_rd;
    endcase
  end

  logic [31:0] gpio_reg, gpio_next;
  logic [1:0]  status_reg, status_next, status_set, status_clr;
  logic [31:0] count_val, compare_val;
  logic        timer_hit;

`ifdef DATA_RAM_TIMER_EN
  logic [31:0] count_reg, compare_reg, compare_next;

  always_comb begin
    compare_next = compare_reg;
    if (mmio_we && mmio_off == 2'd2)
      compare_next = ram_write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= 32'h0;
      compare_reg <= 32'hFFFF_FFFF;
    end else begin
      count_reg   <= count_reg + 32'd1;
      compare_reg <= compare_next;
    end
  end

  assign count_val   = count_reg;
  assign compare_val = compare_reg;
  assign timer_hit   = (count_reg == compare_reg);
`else
  assign count_val   = 32'h0;
  assign compare_val = 32'h0;
  assign timer_hit   = 1'b0;
`endif

  always_comb begin
    gpio_next = gpio_reg;
    if (mmio_we && mmio_off == 2'd0)
      gpio_next = ram_write_data;
    status_clr  = (mmio_we && mmio_off == 2'd3) ? ram_write_data[1:0] : 2'b00;
    status_set  = {enable && illegal, timer_hit};
    // Set is applied after clear so a same-cycle set wins.
    status_next = (status_reg & ~status_clr) | status_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_reg   <= 32'h0;
      status_reg <= 2'b00;
    end else begin
      gpio_reg   <= gpio_next;
      status_reg <= status_next;
    end
  end

  always_comb begin
    case (mmio_off)
      2'd0:    mmio_rd = gpio_reg;
      2'd1:    mmio_rd = count_val;
      2'd2:    mmio_rd = compare_val;
      default: mmio_rd = {30'h0, status_reg};
    endcase
  end

  always_comb begin
    ram_read_data = 32'h0;
    if (!illegal) begin
      if (is_ram)
        ram_read_data = ram_load;
      else if (is_mmio)
        ram_read_data = mmio_rd;
    end
  end

  assign gpio_out  = gpio_reg;
  assign timer_irq = status_reg[0];
endmodule

// File: doc/data_ram.md
# data_ram

Data-memory responder for the single-cycle RV32I core's RAM port. It serves byte, half-word and word loads and stores against a word-organised RAM with byte-lane write masking. It also decodes a small memory-mapped register window containing a GPIO output register, a status register, an optional free-running cycle counter and a compare timer. Reads are combinational so the core completes each load in one cycle; every state change happens on the rising edge of `clk`.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; must be a power of two, 4..65536.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: core advance strobe; stores and W1C actions happen only when high.
- `ram_we` input 1: store request.
- `mem_ctrl` input 2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `alu_res` input 32: byte address.
- `ram_write_data` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `ram_read_data` output 32: load data, right-justified and zero-extended; the core sign-extends it.
- `gpio_out` output 32: GPIO register contents.
- `timer_irq` output 1: level copy of status bit0.
- `misalign_err` output 1: combinational flag for an illegal access in the current cycle.

## Operation
- Address decode on `alu_res[31:28]`:
  - 0x0: RAM; word index = `alu_res[log2(DEPTH)+1:2]`; higher bits are ignored, so the RAM aliases.
  - 0x1: MMIO window; `alu_res[27:4]` is ignored (aliasing).
  - Any other value: unmapped; reads return 0 and writes are ignored with no error.
- MMIO registers, word offset `alu_res[3:2]`:
  - 0x0 GPIO: read/write.
  - 0x4 COUNT: read-only; writes are ignored.
  - 0x8 COMPARE: read/write.
  - 0xC STATUS: bit0 = timer flag, bit1 = misalign sticky; writing 1 to a bit clears it (W1C); other bits read 0.
- Illegal access conditions:
  - `mem_ctrl`=11.
  - Half access with `alu_res[0]`=1.
  - Word access with `alu_res[1:0]`≠0.
  - Any non-word access to the MMIO window.
- An illegal access has these effects:
  - `misalign_err`=1.
  - The store is suppressed.
  - `ram_read_data`=0.
  - Status bit1 is set at the edge when `enable`=1, whether or not `ram_we` is high.
- RAM store: when `enable`&`ram_we`&legal, write the selected lanes.
  - Byte: lane `alu_res[1:0]` gets `ram_write_data[7:0]`.
  - Half: lanes {2·`alu_res[1]`, +1} get `ram_write_data[15:0]`.
  - Word: all four lanes.
- RAM load: select the lane(s) and shift them to bit 0; upper bits are zero.
- Counter: COUNT increments by 1 every clock, independent of `enable`, and wraps 0xFFFF_FFFF→0.
- Timer flag: set at the edge where COUNT == COMPARE (compared before the increment).
- Simultaneous set and W1C of the same status bit in one cycle: the set wins.
- RAM contents are not reset. Simulation init is all zeros.

## Timing
- Load latency is 0 cycles: `ram_read_data` is a combinational function of `alu_res`, `mem_ctrl` and the stored state.
- A store is visible to a load at the same address from the next cycle. A same-cycle load returns the old data.
- A GPIO write reaches `gpio_out` on the edge of the write, i.e. visible the following cycle.
- `timer_irq` rises on the cycle after COUNT equals COMPARE.
- Reset values:
  - `gpio_out`=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0, `timer_irq`=0.
  - `misalign_err` and `ram_read_data` follow their inputs combinationally.
- Reset takes priority over the counter, the store and the status set logic.
- A store presented in the same cycle as `reset` is discarded, for MMIO registers only. A RAM store in that cycle still completes.
- With `enable`=0: no store and no status change (W1C, misalign sticky). COUNT and the timer flag still update.

## Configuration
- `DATA_RAM_TIMER_EN` defined: COUNT, COMPARE and timer-flag logic are present, and `timer_irq` is driven.
- Not defined:
  - COUNT and COMPARE read 0 and ignore writes.
  - Status bit0 reads 0, and `timer_irq` is tied 0.
  - GPIO, RAM and the misalign logic are unchanged.

## Test plan
- Word store 0xDEADBEEF @0x10, then byte loads @0x10..0x13 → 0xEF, 0xBE, 0xAD, 0xDE; half load @0x12 → 0x0000DEAD.
- Byte store 0x55 @0x11 over 0xDEADBEEF → word load 0xDEAD55EF; the same-cycle load @0x10 still returns 0xDEADBEEF.
- Word store @0x6 with `enable`=1:
  - `misalign_err`=1 and the RAM is unchanged.
  - STATUS reads 0x2.
  - After writing 0x2 to 0x1000_000C, STATUS reads 0x0.
- Stores with `enable`=0 (GPIO 0xA5 @0x1000_0000, RAM @0x20) → no change; the same stores with `enable`=1 → `gpio_out`=0xA5 next cycle and the RAM word is updated.
- (`DATA_RAM_TIMER_EN`) After reset, write COMPARE=20 → `timer_irq` rises on the cycle after COUNT reads 20.
  - A W1C of bit0 issued in that same set cycle leaves the flag set.
  - A later W1C clears it.
- Assert `reset` mid-run with COUNT=57 and GPIO=0xFF → next cycle COUNT=0, `gpio_out`=0, STATUS=0, and RAM contents are preserved.
